// File: rtl/user_mgr_arbiter_pkg.sv
// rtl/user_mgr_arbiter_pkg.sv - OBI types, sizing helper and user-domain manager parameters
package user_mgr_arbiter_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
    } obi_cfg_t;

    localparam obi_cfg_t MgrObiCfg = '{AddrWidth: 32, DataWidth: 32};

    localparam int unsigned NumUserMgr      = 2;
    localparam int unsigned UserMgrMaxTrans = 2;

    typedef struct packed {
        logic [MgrObiCfg.AddrWidth-1:0]   addr;
        logic                             we;
        logic [MgrObiCfg.DataWidth/8-1:0] be;
        logic [MgrObiCfg.DataWidth-1:0]   wdata;
    } mgr_obi_a_chan_t;

    typedef struct packed {
        logic            req;
        mgr_obi_a_chan_t a;
    } mgr_obi_req_t;

    typedef struct packed {
        logic [MgrObiCfg.DataWidth-1:0] rdata;
        logic                           err;
    } mgr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        mgr_obi_r_chan_t r;
    } mgr_obi_rsp_t;

    // Index width that stays at least one bit wide for a single entry.
    function automatic int unsigned idx_width(input int unsigned num);
        return (num > 1) ? unsigned'($clog2(num)) : 1;
    endfunction

endpackage

// File: rtl/user_arb_idx_fifo.sv
// rtl/user_arb_idx_fifo.sv - in-order FIFO of manager indices for outstanding transactions
module user_arb_idx_fifo
    import user_mgr_arbiter_pkg::*;
#(
    parameter int unsigned Depth     = 2,
    parameter int unsigned DataWidth = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned PtrW = idx_width(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [CntW-1:0]      cnt_q;
    logic                 do_push;
    logic                 do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/user_mgr_arbiter.sv
// rtl/user_mgr_arbiter.sv - round-robin OBI manager arbiter with A-channel lock and in-order response routing
module user_mgr_arbiter
    import user_mgr_arbiter_pkg::*;
#(
    parameter obi_cfg_t    ObiCfg      = MgrObiCfg,
    parameter type         obi_req_t   = mgr_obi_req_t,
    parameter type         obi_rsp_t   = mgr_obi_rsp_t,
    parameter int unsigned NumMgr      = 2,
    parameter int unsigned NumMaxTrans = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  obi_req_t mgr_req_i [NumMgr],
    output obi_rsp_t mgr_rsp_o [NumMgr],
    output obi_req_t arb_req_o,
    input  obi_rsp_t arb_rsp_i,
    output logic     busy_o
);

    localparam int unsigned IdxW = idx_width(NumMgr);

    if (NumMgr < 1 || NumMaxTrans < 1 || ObiCfg.DataWidth == 0 || ObiCfg.AddrWidth == 0) begin : g_bad_cfg
        $error("user_mgr_arbiter: invalid configuration");
    end

    logic [IdxW-1:0] prio_q;
    logic [IdxW-1:0] sel_q;
    logic            lock_q;
    logic [IdxW-1:0] cand;
    logic [IdxW-1:0] winner;
    logic            found;
    logic [IdxW-1:0] sel;
    logic            handshake;
    logic            fifo_full;
    logic            fifo_empty;
    logic [IdxW-1:0] head_idx;
    logic            pop;

    // First requester at or after prio_q, wrapping modulo NumMgr.
    always_comb begin
        cand   = '0;
        winner = prio_q;
        found  = 1'b0;
        for (int unsigned k = 0; k < NumMgr; k++) begin
            cand = IdxW'((32'(prio_q) + k) % NumMgr);
            if (!found && mgr_req_i[cand].req) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign sel = lock_q ? sel_q : winner;

    always_comb begin
        arb_req_o     = mgr_req_i[sel];
        arb_req_o.req = mgr_req_i[sel].req && !fifo_full;
    end

    assign handshake = arb_req_o.req && arb_rsp_i.gnt;
    assign pop       = arb_rsp_i.rvalid && !fifo_empty;
    assign busy_o    = !fifo_empty;

    always_comb begin
        for (int unsigned i = 0; i < NumMgr; i++) begin
            mgr_rsp_o[i]     = '0;
            mgr_rsp_o[i].gnt = handshake && (IdxW'(i) == sel);
            if (pop && (IdxW'(i) == head_idx)) begin
                mgr_rsp_o[i].rvalid = 1'b1;
                mgr_rsp_o[i].r      = arb_rsp_i.r;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= '0;
            sel_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            // A pending, ungranted request must keep its A-channel until the grant.
            if (arb_req_o.req && !arb_rsp_i.gnt) begin
                lock_q <= 1'b1;
                sel_q  <= sel;
            end else if (handshake) begin
                lock_q <= 1'b0;
            end
            if (handshake) begin
                prio_q <= (32'(sel) + 1 >= NumMgr) ? '0 : sel + 1'b1;
            end
        end
    end

    user_arb_idx_fifo #(
        .Depth     (NumMaxTrans),
        .DataWidth (IdxW)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (handshake),
        .data_i  (sel),
        .pop_i   (pop),
        .data_o  (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    stray_rvalid_chk : assert property (@(posedge clk_i) disable iff (rst_i)
        !(arb_rsp_i.rvalid && fifo_empty))
        else $warning("user_mgr_arbiter: rvalid with no outstanding transaction ignored");

endmodule

// File: tb/tb_user_mgr_arbiter.sv
// tb/tb_user_mgr_arbiter.sv - directed self-checking bench for user_mgr_arbiter
module tb_user_mgr_arbiter;
    import user_mgr_arbiter_pkg::*;

    localparam logic [31:0] ADDR0 = 32'h1000_0000;
    localparam logic [31:0] ADDR1 = 32'h2000_0004;

    logic         clk;
    logic         rst;
    mgr_obi_req_t mgr_req [2];
    mgr_obi_rsp_t mgr_rsp [2];
    mgr_obi_req_t arb_req;
    mgr_obi_rsp_t arb_rsp;
    logic         busy;

    int errors = 0;
    int checks = 0;

    user_mgr_arbiter dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .mgr_req_i (mgr_req),
        .mgr_rsp_o (mgr_rsp),
        .arb_req_o (arb_req),
        .arb_rsp_i (arb_rsp),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        mgr_req[0].req = 1'b0;
        mgr_req[1].req = 1'b0;
        arb_rsp        = '0;
    endtask

    task automatic test_reset;
        mgr_obi_a_chan_t want_a;
        want_a = '{addr: ADDR0, we: 1'b0, be: 4'hF, wdata: 32'h0};
        rst = 1'b1;
        arb_rsp = '0;
        mgr_req[0] = '{req: 1'b1, a: want_a};
        mgr_req[1] = '{req: 1'b0, a: '{addr: ADDR1, we: 1'b0, be: 4'hF, wdata: 32'h0}};
        repeat (3) tick;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if ({mgr_rsp[0].gnt, mgr_rsp[1].gnt, mgr_rsp[0].rvalid, mgr_rsp[1].rvalid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_rsp: gnt0=%b gnt1=%b rv0=%b rv1=%b want all 0",
                     mgr_rsp[0].gnt, mgr_rsp[1].gnt, mgr_rsp[0].rvalid, mgr_rsp[1].rvalid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (arb_req.a !== want_a || arb_req.req !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_a: addr=%h req=%b want addr=%h req=1", arb_req.a.addr, arb_req.req, ADDR0);
        end
        mgr_req[0].req = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_round_robin;
        int          want;
        logic [31:0] want_addr;
        for (int n = 0; n < 5; n++) begin
            mgr_req[0].req = (n < 4);
            mgr_req[1].req = (n < 4);
            arb_rsp.gnt    = 1'b1;
            arb_rsp.rvalid = (n > 0);
            arb_rsp.r.rdata = 32'hA0 + 32'(n) - 32'd1;
            #1;
            if (n < 4) begin
                want = n % 2;
                want_addr = (want == 0) ? ADDR0 : ADDR1;
                checks++;
                if (mgr_rsp[want].gnt !== 1'b1 || mgr_rsp[1-want].gnt !== 1'b0 || arb_req.a.addr !== want_addr) begin
                    errors++;
                    $display("FAIL rr_grant[%0d]: gnt0=%b gnt1=%b addr=%h want mgr%0d addr=%h",
                             n, mgr_rsp[0].gnt, mgr_rsp[1].gnt, arb_req.a.addr, want, want_addr);
                end
            end
            if (n > 0) begin
                want = (n - 1) % 2;
                checks++;
                if (mgr_rsp[want].rvalid !== 1'b1 || mgr_rsp[want].r.rdata !== 32'hA0 + 32'(n) - 32'd1
                    || mgr_rsp[1-want].rvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_rdata[%0d]: rv0=%b rv1=%b rdata=%h want mgr%0d rdata=%h",
                             n, mgr_rsp[0].rvalid, mgr_rsp[1].rvalid, mgr_rsp[want].r.rdata, want, 32'hA0 + n - 1);
                end
            end
            tick;
        end
        idle;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rr_drain_busy: got %b want 0", busy); end
    endtask

    task automatic test_lock;
        for (int c = 0; c < 4; c++) begin
            mgr_req[1].req = 1'b1;
            mgr_req[0].req = (c >= 2);
            arb_rsp.gnt    = 1'b0;
            #1;
            checks++;
            if (arb_req.a.addr !== ADDR1 || arb_req.req !== 1'b1 || mgr_rsp[0].gnt !== 1'b0) begin
                errors++;
                $display("FAIL lock_hold[%0d]: addr=%h req=%b gnt0=%b want addr=%h req=1 gnt0=0",
                         c, arb_req.a.addr, arb_req.req, mgr_rsp[0].gnt, ADDR1);
            end
            tick;
        end
        arb_rsp.gnt = 1'b1;
        #1;
        checks++;
        if (mgr_rsp[1].gnt !== 1'b1 || mgr_rsp[0].gnt !== 1'b0 || arb_req.a.addr !== ADDR1) begin
            errors++;
            $display("FAIL lock_grant: gnt0=%b gnt1=%b addr=%h want gnt1 addr=%h",
                     mgr_rsp[0].gnt, mgr_rsp[1].gnt, arb_req.a.addr, ADDR1);
        end
        tick;
        mgr_req[1].req = 1'b0;
        #1;
        checks++;
        if (mgr_rsp[0].gnt !== 1'b1 || arb_req.a.addr !== ADDR0) begin
            errors++;
            $display("FAIL lock_next: gnt0=%b addr=%h want gnt0=1 addr=%h", mgr_rsp[0].gnt, arb_req.a.addr, ADDR0);
        end
        tick;
        idle;
        arb_rsp.rvalid  = 1'b1;
        arb_rsp.r.rdata = 32'h11;
        #1;
        checks++;
        if (mgr_rsp[1].rvalid !== 1'b1 || mgr_rsp[1].r.rdata !== 32'h11 || mgr_rsp[0].rvalid !== 1'b0) begin
            errors++;
            $display("FAIL lock_rsp1: rv0=%b rv1=%b rdata=%h want rv1 rdata=11",
                     mgr_rsp[0].rvalid, mgr_rsp[1].rvalid, mgr_rsp[1].r.rdata);
        end
        tick;
        arb_rsp.r.rdata = 32'h22;
        #1;
        checks++;
        if (mgr_rsp[0].rvalid !== 1'b1 || mgr_rsp[0].r.rdata !== 32'h22 || mgr_rsp[1].rvalid !== 1'b0) begin
            errors++;
            $display("FAIL lock_rsp0: rv0=%b rv1=%b rdata=%h want rv0 rdata=22",
                     mgr_rsp[0].rvalid, mgr_rsp[1].rvalid, mgr_rsp[0].r.rdata);
        end
        tick;
        idle;
    endtask

    task automatic test_full_fifo;
        mgr_req[0].req = 1'b1;
        mgr_req[1].req = 1'b1;
        arb_rsp.gnt    = 1'b1;
        #1;
        checks++;
        if (mgr_rsp[1].gnt !== 1'b1 || mgr_rsp[0].gnt !== 1'b0) begin
            errors++; $display("FAIL full_grant_a: gnt0=%b gnt1=%b want gnt1", mgr_rsp[0].gnt, mgr_rsp[1].gnt);
        end
        tick;
        checks++;
        if (mgr_rsp[0].gnt !== 1'b1 || mgr_rsp[1].gnt !== 1'b0) begin
            errors++; $display("FAIL full_grant_b: gnt0=%b gnt1=%b want gnt0", mgr_rsp[0].gnt, mgr_rsp[1].gnt);
        end
        tick;
        checks++;
        if (arb_req.req !== 1'b0 || mgr_rsp[0].gnt !== 1'b0 || mgr_rsp[1].gnt !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_block: req=%b gnt0=%b gnt1=%b busy=%b want req=0 gnts=0 busy=1",
                     arb_req.req, mgr_rsp[0].gnt, mgr_rsp[1].gnt, busy);
        end
        tick;
        arb_rsp.rvalid  = 1'b1;
        arb_rsp.r.rdata = 32'h33;
        #1;
        checks++;
        if (arb_req.req !== 1'b0 || mgr_rsp[0].gnt !== 1'b0 || mgr_rsp[1].gnt !== 1'b0
            || mgr_rsp[1].rvalid !== 1'b1 || mgr_rsp[1].r.rdata !== 32'h33) begin
            errors++;
            $display("FAIL full_pop_same_cycle: req=%b gnt0=%b gnt1=%b rv1=%b rdata=%h want req=0 gnts=0 rv1 rdata=33",
                     arb_req.req, mgr_rsp[0].gnt, mgr_rsp[1].gnt, mgr_rsp[1].rvalid, mgr_rsp[1].r.rdata);
        end
        tick;
        arb_rsp.rvalid = 1'b0;
        #1;
        checks++;
        if (arb_req.req !== 1'b1 || mgr_rsp[1].gnt !== 1'b1 || mgr_rsp[0].gnt !== 1'b0) begin
            errors++;
            $display("FAIL full_resume: req=%b gnt0=%b gnt1=%b want req=1 gnt1",
                     arb_req.req, mgr_rsp[0].gnt, mgr_rsp[1].gnt);
        end
        tick;
        idle;
        arb_rsp.rvalid  = 1'b1;
        arb_rsp.r.rdata = 32'h44;
        #1;
        checks++;
        if (mgr_rsp[0].rvalid !== 1'b1 || mgr_rsp[0].r.rdata !== 32'h44 || mgr_rsp[1].rvalid !== 1'b0) begin
            errors++;
            $display("FAIL full_rsp0: rv0=%b rv1=%b rdata=%h want rv0 rdata=44",
                     mgr_rsp[0].rvalid, mgr_rsp[1].rvalid, mgr_rsp[0].r.rdata);
        end
        tick;
        arb_rsp.r.rdata = 32'h55;
        #1;
        checks++;
        if (mgr_rsp[1].rvalid !== 1'b1 || mgr_rsp[1].r.rdata !== 32'h55 || mgr_rsp[0].rvalid !== 1'b0) begin
            errors++;
            $display("FAIL full_rsp1: rv0=%b rv1=%b rdata=%h want rv1 rdata=55",
                     mgr_rsp[0].rvalid, mgr_rsp[1].rvalid, mgr_rsp[1].r.rdata);
        end
        tick;
        idle;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL full_drain_busy: got %b want 0", busy); end
    endtask

    task automatic test_error;
        mgr_req[1].req = 1'b1;
        arb_rsp.gnt    = 1'b1;
        #1;
        checks++;
        if (mgr_rsp[1].gnt !== 1'b1 || mgr_rsp[0].gnt !== 1'b0) begin
            errors++; $display("FAIL err_grant: gnt0=%b gnt1=%b want gnt1", mgr_rsp[0].gnt, mgr_rsp[1].gnt);
        end
        tick;
        idle;
        arb_rsp.rvalid  = 1'b1;
        arb_rsp.r.err   = 1'b1;
        arb_rsp.r.rdata = 32'hBADC_AB1E;
        #1;
        checks++;
        if (mgr_rsp[1].rvalid !== 1'b1 || mgr_rsp[1].r.err !== 1'b1 || mgr_rsp[1].r.rdata !== 32'hBADC_AB1E
            || mgr_rsp[0].rvalid !== 1'b0 || mgr_rsp[0].r.err !== 1'b0) begin
            errors++;
            $display("FAIL err_route: rv0=%b err0=%b rv1=%b err1=%b rdata1=%h want rv1 err1 rdata1=badcab1e only",
                     mgr_rsp[0].rvalid, mgr_rsp[0].r.err, mgr_rsp[1].rvalid, mgr_rsp[1].r.err, mgr_rsp[1].r.rdata);
        end
        tick;
        idle;
    endtask

    task automatic test_stray;
        arb_rsp.rvalid  = 1'b1;
        arb_rsp.r.rdata = 32'hDEAD;
        #1;
        checks++;
        if (mgr_rsp[0].rvalid !== 1'b0 || mgr_rsp[1].rvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_ignored: rv0=%b rv1=%b busy=%b want all 0", mgr_rsp[0].rvalid, mgr_rsp[1].rvalid, busy);
        end
        tick;
        idle;
        mgr_req[0].req = 1'b1;
        mgr_req[1].req = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || arb_req.a.addr !== ADDR0 || arb_req.req !== 1'b1) begin
            errors++;
            $display("FAIL stray_state: busy=%b addr=%h req=%b want busy=0 addr=%h req=1",
                     busy, arb_req.a.addr, arb_req.req, ADDR0);
        end
        tick;
        idle;
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_lock;
        test_full_fifo;
        test_error;
        test_stray;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/user_mgr_arbiter.md
# user_mgr_arbiter

Round-robin arbiter that shares the single user-domain OBI manager port (`user_mgr_obi_req_o` / `user_mgr_obi_rsp_i` of `user_domain`) between `NumMgr` user-domain managers. It holds the request stable until it is granted, tracks outstanding transactions in order, and routes each response back to the manager that issued it. It sits inside `user_domain` and replaces the constant-zero tie-off of the manager port once user managers exist.

## Interface
- `ObiCfg`, default `MgrObiCfg`: OBI configuration of both sides.
- `obi_req_t`, default `mgr_obi_req_t`: OBI request struct.
- `obi_rsp_t`, default `mgr_obi_rsp_t`: OBI response struct.
- `NumMgr`, default 2: number of requesting managers, ≥1.
- `NumMaxTrans`, default 2: maximum outstanding downstream transactions, ≥1.
- `clk_i`, input, 1: the only clock.
- `rst_i`, input, 1: reset, synchronous and active-high.
- `mgr_req_i`, input, `obi_req_t [NumMgr]`: upstream requests.
- `mgr_rsp_o`, output, `obi_rsp_t [NumMgr]`: upstream responses.
- `arb_req_o`, output, `obi_req_t`: downstream request, connects to `user_mgr_obi_req_o`.
- `arb_rsp_i`, input, `obi_rsp_t`: downstream response.
- `busy_o`, output, 1: high while any transaction is outstanding.

## Operation
- **Candidate selection.**
  - Candidates are the managers with `mgr_req_i[i].req` high.
  - The winner is the first candidate at or after `prio_q`, scanning upward with wrap-around modulo `NumMgr`.
- **Lock.**
  - When `arb_req_o.req` is high and `arb_rsp_i.gnt` is low, `lock_q` is set and `sel_q` holds the winner.
  - While `lock_q` is set, the selection is `sel_q` regardless of other requests.
  - `lock_q` clears on the grant.
  - This keeps the A-channel stable, as OBI requires.
- **Issue.**
  - `arb_req_o.a` always carries the A-channel of the selected manager.
  - `arb_req_o.req` = selected manager's `req` AND not `fifo_full`.
  - Only the selected manager receives `gnt` = `arb_rsp_i.gnt` AND `arb_req_o.req`. All other managers see `gnt` = 0.
- **Handshake** (`arb_req_o.req` && `arb_rsp_i.gnt`):
  - push the selected index into the ID FIFO;
  - set `prio_q` to (selected + 1) mod `NumMgr`.
- **Response.**
  - On `arb_rsp_i.rvalid`, the FIFO head index `h` is popped.
  - `mgr_rsp_o[h].rvalid` = 1, and `mgr_rsp_o[h].r` = `arb_rsp_i.r`, including `err`.
  - All other managers see `rvalid` = 0.
  - Responses are returned in order.
- **Full FIFO.** When `fifo_full`, `arb_req_o.req` = 0 even if `rvalid` is high in the same cycle. This avoids any combinational rvalid→req path.
- **Simultaneous push and pop** (when not full): FIFO count is unchanged and the head advances.
- **rvalid with an empty FIFO** is a protocol violation:
  - it is ignored and no upstream `rvalid` is generated;
  - a simulation assertion fires.
- **`NumMgr` = 1:** pass-through plus FIFO gating; `prio_q` stays 0.
- **`busy_o`** = FIFO not empty.

## Timing
- **Reset values:**
  - `prio_q` = 0, `lock_q` = 0, `sel_q` = 0, FIFO empty;
  - `arb_req_o.req` = 0 unless a manager requests;
  - all `mgr_rsp_o` `gnt`/`rvalid` = 0; `busy_o` = 0.
- **Latencies (all zero-cycle, combinational):**
  - req→`arb_req_o.req`;
  - `gnt`→upstream `gnt`;
  - `rvalid`/`r`→upstream.
- **State updates:** `prio_q`, `lock_q`, `sel_q` and the FIFO update on the rising `clk_i` edge after the event.
- **Reset mid-transaction:**
  - all state clears in the next cycle;
  - in-flight responses arriving after reset are treated as rvalid-on-empty;
  - downstream is reset together with this block.
- **Width rules:**
  - index width is `cf_math_pkg::idx_width(NumMgr)`;
  - FIFO count width is `$clog2(NumMaxTrans+1)`;
  - FIFO pointers wrap modulo `NumMaxTrans`.

## Structure
- **`user_pkg`** additions:
  - `NumUserMgr` (number of user managers);
  - `UserMgrMaxTrans` (default 2), used by `user_domain` to instantiate this block.
- **Sub-module `user_arb_idx_fifo`:**
  - synchronous active-high reset FIFO;
  - parameters `Depth` and `DataWidth`;
  - push/pop with full and empty flags;
  - fall-through-free (head valid the cycle after push).
- **Top level** holds the round-robin scan, the lock register and the response routing.

## Test plan
- **Reset:** hold `rst_i` high for 3 cycles with manager 0 requesting and `gnt` = 0. Then `busy_o` = 0, all upstream `gnt`/`rvalid` = 0, FIFO empty, and after release `arb_req_o.a` equals manager 0's A-channel.
- **Round-robin:** both managers request continuously, `gnt` is always 1, rvalid comes 1 cycle later. Grants alternate 0,1,0,1, and each `rdata` (0xA0+n) reaches the manager that issued it.
- **Lock:** manager 1 requests with `gnt` held low for 4 cycles while manager 0 asserts `req` on cycle 2. `arb_req_o.a.addr` stays at manager 1's 0x2000_0004 until the grant; manager 0 is served next.
- **Full FIFO:** `NumMaxTrans` = 2, 2 grants issued with no rvalid. `arb_req_o.req` = 0 and no upstream `gnt`. On the first `rvalid`, issue resumes in the next cycle, not the same cycle.
- **Error path:** the downstream returns `err` = 1 with `rdata` 0xBADCAB1E for manager 1's read. Only `mgr_rsp_o[1]` shows `rvalid` = 1 and `err` = 1.
- **Stray response:** `rvalid` = 1 with an empty FIFO. No upstream `rvalid`, the assertion fires, and state is unchanged.
